// File: rtl/sprite_line_loader_if.sv
// OAM read port, VRAM pattern-fetch handshake and shifter push port of the sprite line loader.
interface sprite_line_loader_if;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        vram_req;
  logic [13:0] vram_addr;
  logic        vram_ack;
  logic [7:0]  vram_data;
  logic [3:0]  load;
  logic [26:0] load_in;

  modport master (
    output oam_addr,
    input  oam_data,
    output vram_req,
    output vram_addr,
    input  vram_ack,
    input  vram_data,
    output load,
    output load_in
  );

  modport slave (
    input  oam_addr,
    output oam_data,
    input  vram_req,
    input  vram_addr,
    output vram_ack,
    output vram_data,
    input  load,
    input  load_in
  );
endinterface

// File: rtl/sprite_line_loader.sv
// Scans OAM for sprites on the next line, fetches their pattern bytes and pushes
// NumSlots entries into the sprite shifter, slot 0 first.
module sprite_line_loader #(
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned OamEntries = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 start_eval,
  input  logic                 start_fetch,
  input  logic [8:0]           scanline,
  input  logic                 obj_size,
  input  logic                 obj_patt,
  sprite_line_loader_if.master bus,
  output logic                 sprite0_on_line,
  output logic                 overflow,
  output logic                 busy
);
  localparam int unsigned SlotW  = $clog2(NumSlots);
  localparam int unsigned HitW   = $clog2(NumSlots + 1);
  localparam int unsigned EntryW = $clog2(OamEntries);

  typedef enum logic [2:0] {StIdle, StEval, StEvalDone, StFetchLo, StFetchHi, StPush} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   entry_q, entry_d;
  logic [2:0]          phase_q, phase_d;
  logic [HitW-1:0]     hits_q, hits_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [7:0]          lo_q, lo_d, hi_q, hi_d;
  logic [26:0]         load_in_q, load_in_d;
  logic                sprite0_q, sprite0_d, overflow_q, overflow_d;

  // Secondary buffer; attr keeps {vflip, hflip, prio, pal[1:0]}
  logic [7:0]          tile_q [NumSlots];
  logic [4:0]          attr_q [NumSlots];
  logic [7:0]          x_q    [NumSlots];
  logic [3:0]          row_q  [NumSlots];
  logic                wr_row, wr_tile, wr_attr, wr_x, next_entry;

  logic [8:0]          dy;
  logic                in_range, live, plane;
  logic [3:0]          row_eff;
  logic [13:0]         fetch_addr;
  logic [7:0]          pat;
  logic [26:0]         push_word;
  logic [SlotW-1:0]    wr_idx;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  assign dy       = scanline - {1'b0, bus.oam_data};
  assign in_range = obj_size ? (dy < 9'd16) : (dy < 9'd8);
  assign wr_idx   = hits_q[SlotW-1:0];
  assign live     = HitW'(slot_q) < hits_q;
  assign plane    = (state_q == StFetchHi);

  always_comb begin
    row_eff = row_q[slot_q];
    if (attr_q[slot_q][4]) row_eff = obj_size ? ~row_q[slot_q] : {row_q[slot_q][3], ~row_q[slot_q][2:0]};
    if (obj_size) begin
      fetch_addr = {1'b0, tile_q[slot_q][0], tile_q[slot_q][7:1], row_eff[3], plane, row_eff[2:0]};
    end else begin
      fetch_addr = {1'b0, obj_patt, tile_q[slot_q], plane, row_eff[2:0]};
    end
    pat       = attr_q[slot_q][3] ? rev8(bus.vram_data) : bus.vram_data;
    push_word = live ? {x_q[slot_q], attr_q[slot_q][2:0], lo_q, hi_q} : {8'hFF, 3'b000, 16'h0000};
  end

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    phase_d    = phase_q;
    hits_d     = hits_q;
    slot_d     = slot_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    load_in_d  = load_in_q;
    sprite0_d  = sprite0_q;
    overflow_d = overflow_q;
    wr_row     = 1'b0;
    wr_tile    = 1'b0;
    wr_attr    = 1'b0;
    wr_x       = 1'b0;
    next_entry = 1'b0;
    if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (start_eval) begin
            state_d    = StEval;
            entry_d    = '0;
            phase_d    = 3'd0;
            hits_d     = '0;
            sprite0_d  = 1'b0;
            overflow_d = 1'b0;
          end
        end
        StEval: begin
          // phase 1 tests Y; phases 2..4 capture tile, attr, x of a hit
          case (phase_q)
            3'd0: phase_d = 3'd1;
            3'd1: begin
              if (!in_range) begin
                next_entry = 1'b1;
              end else if (hits_q == HitW'(NumSlots)) begin
                overflow_d = 1'b1;
                state_d    = StEvalDone;
              end else begin
                wr_row  = 1'b1;
                phase_d = 3'd2;
                if (entry_q == '0) sprite0_d = 1'b1;
              end
            end
            3'd2: begin wr_tile = 1'b1; phase_d = 3'd3; end
            3'd3: begin wr_attr = 1'b1; phase_d = 3'd4; end
            3'd4: begin wr_x = 1'b1; hits_d = hits_q + 1'b1; next_entry = 1'b1; end
            default: phase_d = 3'd0;
          endcase
          if (next_entry) begin
            if (entry_q == EntryW'(OamEntries - 1)) begin
              state_d = StEvalDone;
            end else begin
              entry_d = entry_q + 1'b1;
              phase_d = 3'd0;
            end
          end
        end
        StEvalDone: begin
          if (start_fetch) begin
            slot_d  = '0;
            state_d = (hits_q != '0) ? StFetchLo : StPush;
          end
        end
        StFetchLo: begin
          if (bus.vram_ack) begin
            lo_d    = pat;
            state_d = StFetchHi;
          end
        end
        StFetchHi: begin
          if (bus.vram_ack) begin
            hi_d    = pat;
            state_d = StPush;
          end
        end
        StPush: begin
          load_in_d = push_word;
          if (slot_q == SlotW'(NumSlots - 1)) begin
            state_d = StIdle;
          end else begin
            slot_d  = slot_q + 1'b1;
            state_d = (HitW'(slot_q) + 1'b1 < hits_q) ? StFetchLo : StPush;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      phase_q    <= 3'd0;
      hits_q     <= '0;
      slot_q     <= '0;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      load_in_q  <= '0;
      sprite0_q  <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        tile_q[i] <= 8'h00;
        attr_q[i] <= 5'h00;
        x_q[i]    <= 8'h00;
        row_q[i]  <= 4'h0;
      end
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      phase_q    <= phase_d;
      hits_q     <= hits_d;
      slot_q     <= slot_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      load_in_q  <= load_in_d;
      sprite0_q  <= sprite0_d;
      overflow_q <= overflow_d;
      if (wr_row)  row_q[wr_idx]  <= dy[3:0];
      if (wr_tile) tile_q[wr_idx] <= bus.oam_data;
      if (wr_attr) attr_q[wr_idx] <= {bus.oam_data[7:5], bus.oam_data[1:0]};
      if (wr_x)    x_q[wr_idx]    <= bus.oam_data;
    end
  end

  always_comb begin
    busy            = (state_q != StIdle);
    sprite0_on_line = sprite0_q;
    overflow        = overflow_q;
    bus.oam_addr    = 8'h00;
    if (state_q == StEval) bus.oam_addr = {entry_q, (phase_q >= 3'd3) ? 2'd3 : phase_q[1:0]};
    bus.vram_req    = (state_q == StFetchLo) || (state_q == StFetchHi);
    bus.vram_addr   = bus.vram_req ? fetch_addr : 14'h0000;
    bus.load        = (state_q == StPush && ce) ? 4'hF : 4'h0;
    bus.load_in     = (state_q == StPush && ce) ? push_word : load_in_q;
  end
endmodule
